// File: rtl/serial_sub8.sv
// Bit-serial 8-bit two's-complement subtractor.
// Computes A - B as A + ~B + 1, one bit per clock, LSB first.
// A start in IDLE latches the operands; eight SHIFT cycles follow,
// then a single DONE cycle. diff, overflow and borrow are loaded
// only on the final SHIFT edge and otherwise hold their values.
module serial_sub8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic       busy,
   output logic       done,
   output logic [7:0] diff,
   output logic       overflow,
   output logic       borrow
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t     state, state_nx;
   logic [7:0] a_sh, b_sh, res_sh;
   logic [2:0] cnt;
   logic       carry;
   logic       bit_a, bit_nb, sum_bit, carry_nx, last_bit;

   // One full-adder slice over the current LSBs of A and ~B
   always_comb begin
      bit_a    = a_sh[0];
      bit_nb   = ~b_sh[0];
      sum_bit  = bit_a ^ bit_nb ^ carry;
      carry_nx = (bit_a & bit_nb) | (bit_a & carry) | (bit_nb & carry);
      last_bit = (cnt == 3'd7);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic and status outputs decoded from the state
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand/result shifting and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         diff     <= '0;
         overflow <= 1'b0;
         borrow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  cnt   <= '0;
                  carry <= 1'b1;
               end
            end
            SHIFT: begin
               res_sh <= {sum_bit, res_sh[7:1]};
               a_sh   <= {1'b0, a_sh[7:1]};
               b_sh   <= {1'b0, b_sh[7:1]};
               cnt    <= cnt + 3'd1;
               carry  <= carry_nx;
               if (last_bit) begin
                  // On the last bit the operand LSBs are the latched sign bits
                  diff     <= {sum_bit, res_sh[7:1]};
                  overflow <= (bit_a ^ ~bit_nb) & (sum_bit ^ bit_a);
                  borrow   <= ~carry_nx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: the driver pushes the expected
// result and acceptance cycle; a negedge monitor checks busy, done,
// result hold and the result itself against a plain-arithmetic model.
module tb_serial_sub8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] A, B;
   logic       busy, done, overflow, borrow;
   logic [7:0] diff;

   typedef struct {
      logic [7:0] d;
      logic       ov;
      logic       br;
      int         n;
   } exp_t;

   exp_t       q[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] hold_d = '0;
   logic       hold_ov = 1'b0;
   logic       hold_br = 1'b0;

   serial_sub8 dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .diff(diff), .overflow(overflow), .borrow(borrow)
   );

   always #5 clk = ~clk;

   // Edge count: after rising edge k, cyc == k
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int n);
      exp_t r;
      int   sa, sb, sd;
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      sd   = sa - sb;
      r.d  = a - b;
      r.ov = (sd < -128) || (sd > 127);
      r.br = (a < b);
      r.n  = n;
      return r;
   endfunction

   // Monitor: mid-cycle sampling of all outputs against the queue head
   always @(negedge clk) begin : mon
      exp_t t;
      logic busy_exp;
      if (!rst_n) begin
         q.delete();
         hold_d  = '0;
         hold_ov = 1'b0;
         hold_br = 1'b0;
      end else begin
         busy_exp = (q.size() > 0) && (cyc >= q[0].n) && (cyc <= q[0].n + 7);
         chk("busy", {7'b0, busy}, {7'b0, busy_exp});
         if (q.size() > 0 && cyc == q[0].n + 8) begin
            t = q.pop_front();
            chk("done", {7'b0, done}, 8'h01);
            chk("diff", diff, t.d);
            chk("overflow", {7'b0, overflow}, {7'b0, t.ov});
            chk("borrow", {7'b0, borrow}, {7'b0, t.br});
            hold_d  = t.d;
            hold_ov = t.ov;
            hold_br = t.br;
         end else begin
            chk("done_idle", {7'b0, done}, 8'h00);
            chk("diff_hold", diff, hold_d);
            chk("ovf_hold", {7'b0, overflow}, {7'b0, hold_ov});
            chk("borrow_hold", {7'b0, borrow}, {7'b0, hold_br});
         end
      end
   end

   // Issue one operation; entered and left at posedge+1 with the DUT idle
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit garble);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk); #1;
      q.push_back(model(a, b, cyc));
      start = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         if (garble) begin
            A = 8'($urandom);
            B = 8'($urandom);
         end
         @(posedge clk); #1;
         start = (garble && i == 3);
      end
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] ta[8];
      logic [7:0] tb[8];
      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      #2;
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_done", {7'b0, done}, 8'h00);
      chk("rst_diff", diff, 8'h00);
      chk("rst_ovf", {7'b0, overflow}, 8'h00);
      chk("rst_borrow", {7'b0, borrow}, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      ta = '{8'h05, 8'h80, 8'h7F, 8'h03, 8'h00, 8'h80, 8'h00, 8'h7F};
      tb = '{8'h03, 8'h01, 8'hFF, 8'h05, 8'h00, 8'h80, 8'h80, 8'h80};
      for (int i = 0; i < 8; i++) issue(ta[i], tb[i], (i == 3));

      // start held high for 30 edges: accepted at N, N+10, N+20
      A     = 8'h10;
      B     = 8'h01;
      start = 1'b1;
      @(posedge clk); #1;
      q.push_back(model(8'h10, 8'h01, cyc));
      for (int i = 1; i < 30; i++) begin
         @(posedge clk); #1;
         if (i == 10 || i == 20) q.push_back(model(8'h10, 8'h01, cyc));
      end
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Reset in the middle of an operation
      A     = 8'h44;
      B     = 8'h21;
      start = 1'b1;
      @(posedge clk); #1;
      q.push_back(model(8'h44, 8'h21, cyc));
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {7'b0, busy}, 8'h00);
      chk("abort_done", {7'b0, done}, 8'h00);
      chk("abort_diff", diff, 8'h00);
      chk("abort_ovf", {7'b0, overflow}, 8'h00);
      chk("abort_borrow", {7'b0, borrow}, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      issue(8'h22, 8'h11, 1'b0);

      // Randomised operations with idle gaps and ignored mid-busy starts
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      repeat (3) begin @(posedge clk); #1; end
      chk("queue_empty", 8'(q.size()), 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
